regfile_wb_arbiter: RTL and testbench

//  Sole writer of the register file write port (rd_num/rd_data/rd_we). Merges

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole regfile writer merging pipeline results with a long-latency FIFO, plus RAW scoreboard.
// Optional WB_ERR_EN macro enables sticky protocol-error detection on o_err.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pipe_we,
    input  logic [4:0]  i_pipe_num,
    input  logic [31:0] i_pipe_data,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_num,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,
    input  logic        i_sb_set,
    input  logic [4:0]  i_sb_num,
    output logic        o_sb_full,
    input  logic [4:0]  i_rs_num,
    input  logic [4:0]  i_rt_num,
    output logic        o_rs_busy,
    output logic        o_rt_busy,
    output logic [4:0]  o_rd_num,
    output logic [31:0] o_rd_data,
    output logic        o_rd_we,
    output logic        o_drained,
    output logic        o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [4:0]               r_fnum  [DEPTH];
    logic [31:0]              r_fdata [DEPTH];
    logic [AW-1:0]            r_wp, r_rp;
    logic [AW:0]              r_cnt;
    logic [31:0][CNT_W-1:0]   r_pend;
    logic                     r_rd_we;
    logic [4:0]               r_rd_num;
    logic [31:0]              r_rd_data;

    logic        w_full, w_empty, w_pipe, w_pop, w_pop_wr, w_push, w_inc;
    logic [4:0]  w_head_num;
    logic [31:0] w_head_data, w_up, w_dn, w_nz;

    assign w_full      = r_cnt == (AW+1)'(DEPTH);
    assign w_empty     = r_cnt == '0;
    assign w_head_num  = r_fnum[r_rp];
    assign w_head_data = r_fdata[r_rp];
    assign w_pipe      = i_pipe_we && i_pipe_num != 5'd0;
    assign w_pop       = !w_pipe && !w_empty;
    assign w_pop_wr    = w_pop && w_head_num != 5'd0;
    assign w_push      = i_lu_valid && o_lu_ready;
    assign w_inc       = i_sb_set && i_sb_num != 5'd0;
    assign w_up        = w_inc ? 32'd1 << i_sb_num : '0;
    assign w_dn        = w_pop_wr ? 32'd1 << w_head_num : '0;

    always_comb begin
        w_nz = '0;
        for (int i = 0; i < 32; i++) w_nz[i] = r_pend[i] != '0;
    end

    assign o_lu_ready = !w_full && !rst;
    assign o_rs_busy  = w_nz[i_rs_num];
    assign o_rt_busy  = w_nz[i_rt_num];
    assign o_sb_full  = r_pend[i_sb_num] == CMAX;
    assign o_drained  = w_empty && w_nz == '0;
    assign o_rd_we    = r_rd_we;
    assign o_rd_num   = r_rd_num;
    assign o_rd_data  = r_rd_data;

    always_ff @(posedge clk)
        if (w_push) begin
            r_fnum[r_wp]  <= i_lu_num;
            r_fdata[r_wp] <= i_lu_data;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Pipeline results win the port; a popped r0 entry is consumed without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_we   <= 1'b0;
            r_rd_num  <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_we <= w_pipe || w_pop_wr;
            if (w_pipe) begin
                r_rd_num  <= i_pipe_num;
                r_rd_data <= i_pipe_data;
            end else if (w_pop_wr) begin
                r_rd_num  <= w_head_num;
                r_rd_data <= w_head_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else
            for (int i = 0; i < 32; i++)
                if (w_up[i] && !w_dn[i] && r_pend[i] != CMAX) r_pend[i] <= r_pend[i] + CNT_W'(1);
                else if (w_dn[i] && !w_up[i] && w_nz[i]) r_pend[i] <= r_pend[i] - CNT_W'(1);
    end

`ifdef WB_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if ((i_lu_valid && w_full) || (i_sb_set && o_sb_full) ||
                 (w_pop_wr && !w_nz[w_head_num]) || (w_pipe && w_nz[i_pipe_num]))
            r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table, corner sequences and random stimulus vs a queue-based model.
module tb_regfile_wb_arbiter;
    logic        clk, rst;
    logic        pipe_we, lu_valid, sb_set;
    logic [4:0]  pipe_num, lu_num, sb_num, rs_num, rt_num;
    logic [31:0] pipe_data, lu_data;
    logic        lu_ready, sb_full, rs_busy, rt_busy, rd_we, drained, err;
    logic [4:0]  rd_num;
    logic [31:0] rd_data;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pipe_we(pipe_we), .i_pipe_num(pipe_num), .i_pipe_data(pipe_data),
        .i_lu_valid(lu_valid), .i_lu_num(lu_num), .i_lu_data(lu_data), .o_lu_ready(lu_ready),
        .i_sb_set(sb_set), .i_sb_num(sb_num), .o_sb_full(sb_full),
        .i_rs_num(rs_num), .i_rt_num(rt_num), .o_rs_busy(rs_busy), .o_rt_busy(rt_busy),
        .o_rd_num(rd_num), .o_rd_data(rd_data), .o_rd_we(rd_we),
        .o_drained(drained), .o_err(err)
    );

`ifdef WB_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, pending writes as plain integers.
    typedef struct { logic [4:0] n; logic [31:0] d; } ent_t;
    ent_t        q[$];
    int          pend[32];
    logic        m_we;
    logic [4:0]  m_num;
    logic [31:0] m_data;
    logic        m_err;

    function automatic logic m_drained();
        int s = 0;
        for (int i = 0; i < 32; i++) s += pend[i];
        return q.size() == 0 && s == 0;
    endfunction

    task automatic model_edge();
        ent_t h;
        logic psel, pop, full;
        int d, v;
        if (rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
            m_we = 0; m_num = 0; m_data = 0; m_err = 0;
            return;
        end
        full = q.size() == 4;
        psel = pipe_we && pipe_num != 0;
        pop  = !psel && q.size() != 0;
        h    = pop ? q[0] : '{n: 5'd0, d: 32'd0};
        if (ERR_ON && ((lu_valid && full) || (sb_set && pend[sb_num] == 3) ||
                       (pop && h.n != 0 && pend[h.n] == 0) || (psel && pend[pipe_num] != 0)))
            m_err = 1;
        if (psel) begin
            m_we = 1; m_num = pipe_num; m_data = pipe_data;
        end else if (pop && h.n != 0) begin
            m_we = 1; m_num = h.n; m_data = h.d;
        end else m_we = 0;
        for (int i = 1; i < 32; i++) begin
            d = int'(sb_set && sb_num == i) - int'(pop && h.n == i);
            v = pend[i] + d;
            pend[i] = v < 0 ? 0 : (v > 3 ? 3 : v);
        end
        if (pop) void'(q.pop_front());
        if (lu_valid && !full) q.push_back('{n: lu_num, d: lu_data});
    endtask

    task automatic step();
        #1;
        chk("lu_ready", lu_ready, !rst && q.size() < 4);
        chk("rs_busy", rs_busy, pend[rs_num] != 0);
        chk("rt_busy", rt_busy, pend[rt_num] != 0);
        chk("sb_full", sb_full, pend[sb_num] == 3);
        chk("drained", drained, m_drained());
        chk("err", err, m_err);
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_we", rd_we, m_we);
        chk("rd_num", rd_num, m_num);
        chk("rd_data", rd_data, m_data);
    endtask

    task automatic idle();
        pipe_we = 0; pipe_num = 0; pipe_data = 0;
        lu_valid = 0; lu_num = 0; lu_data = 0;
        sb_set = 0; sb_num = 0; rs_num = 0; rt_num = 0;
    endtask

    typedef struct {
        logic pwe; logic [4:0] pnum; logic [31:0] pdata;
        logic lv; logic [4:0] lnum; logic [31:0] ldata;
        logic sbs; logic [4:0] sbn; logic [4:0] rs;
        logic e_busy; logic e_we; logic [4:0] e_num; logic [31:0] e_data; logic e_drained;
    } vec_t;
    vec_t tv[19];

    initial begin
        // pwe pnum pdata | lv lnum ldata | sbs sbn rs || busy we num data drained
        tv[0]  = '{0, 0, 0,       0, 0, 0,            1, 8, 8,  0, 0, 0, 0,            0};
        tv[1]  = '{0, 0, 0,       1, 8, 32'hDEADBEEF, 0, 0, 8,  1, 0, 0, 0,            0};
        tv[2]  = '{0, 0, 0,       0, 0, 0,            0, 0, 8,  1, 1, 8, 32'hDEADBEEF, 1};
        tv[3]  = '{0, 0, 0,       0, 0, 0,            0, 0, 8,  0, 0, 8, 32'hDEADBEEF, 1};
        tv[4]  = '{0, 0, 0,       1, 0, 32'h1234,     0, 0, 0,  0, 0, 8, 32'hDEADBEEF, 0};
        tv[5]  = '{0, 0, 0,       0, 0, 0,            0, 0, 0,  0, 0, 8, 32'hDEADBEEF, 1};
        tv[6]  = '{0, 0, 0,       0, 0, 0,            1, 5, 5,  0, 0, 8, 32'hDEADBEEF, 0};
        tv[7]  = '{0, 0, 0,       0, 0, 0,            1, 5, 5,  1, 0, 8, 32'hDEADBEEF, 0};
        tv[8]  = '{0, 0, 0,       1, 5, 32'h55,       0, 0, 5,  1, 0, 8, 32'hDEADBEEF, 0};
        tv[9]  = '{0, 0, 0,       1, 5, 32'h56,       0, 0, 5,  1, 1, 5, 32'h55,       0};
        tv[10] = '{1, 0, 32'hBAD, 0, 0, 0,            0, 0, 5,  1, 1, 5, 32'h56,       1};
        tv[11] = '{0, 0, 0,       0, 0, 0,            0, 0, 5,  0, 0, 5, 32'h56,       1};
        tv[12] = '{0, 0, 0,       0, 0, 0,            1, 6, 6,  0, 0, 5, 32'h56,       0};
        tv[13] = '{0, 0, 0,       1, 6, 32'h66,       0, 0, 6,  1, 0, 5, 32'h56,       0};
        tv[14] = '{0, 0, 0,       0, 0, 0,            1, 6, 6,  1, 1, 6, 32'h66,       0};
        tv[15] = '{0, 0, 0,       0, 0, 0,            0, 0, 6,  1, 0, 6, 32'h66,       0};
        tv[16] = '{0, 0, 0,       1, 6, 32'h67,       0, 0, 6,  1, 0, 6, 32'h66,       0};
        tv[17] = '{0, 0, 0,       0, 0, 0,            0, 0, 6,  1, 1, 6, 32'h67,       1};
        tv[18] = '{0, 0, 0,       0, 0, 0,            0, 0, 6,  0, 0, 6, 32'h67,       1};

        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("reset_rd_we", rd_we, 0);
        chk("reset_rd_num", rd_num, 0);
        chk("reset_rd_data", rd_data, 0);

        foreach (tv[i]) begin
            pipe_we = tv[i].pwe; pipe_num = tv[i].pnum; pipe_data = tv[i].pdata;
            lu_valid = tv[i].lv; lu_num = tv[i].lnum; lu_data = tv[i].ldata;
            sb_set = tv[i].sbs; sb_num = tv[i].sbn; rs_num = tv[i].rs; rt_num = tv[i].rs;
            #1;
            chk($sformatf("tv%0d_busy", i), rs_busy, tv[i].e_busy);
            step();
            chk($sformatf("tv%0d_we", i), rd_we, tv[i].e_we);
            chk($sformatf("tv%0d_num", i), rd_num, tv[i].e_num);
            chk($sformatf("tv%0d_data", i), rd_data, tv[i].e_data);
            chk($sformatf("tv%0d_drained", i), drained, tv[i].e_drained);
        end
        idle();

        // Pipeline keeps the port for 6 cycles while the FIFO fills, then drains in order.
        for (int k = 0; k < 4; k++) begin
            sb_set = 1; sb_num = 5'(9 + k);
            step();
        end
        sb_set = 0;
        for (int k = 0; k < 6; k++) begin
            pipe_we = 1; pipe_num = 3; pipe_data = 32'h300 + k;
            lu_valid = k < 4; lu_num = 5'(9 + k); lu_data = 32'h900 + k;
            step();
            chk("t2_pipe_we", rd_we, 1);
            chk("t2_pipe_num", rd_num, 3);
            if (k == 3) chk("t2_lu_ready_full", lu_ready, 0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_drain_we", rd_we, 1);
            chk("t2_drain_num", rd_num, 9 + k);
            chk("t2_drain_data", rd_data, 32'h900 + k);
        end

        // Reset in the middle of a drain discards everything.
        for (int k = 0; k < 3; k++) begin
            sb_set = 1; sb_num = 5'(20 + k);
            step();
        end
        sb_set = 0;
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1; pipe_num = 1; pipe_data = k;
            lu_valid = 1; lu_num = 5'(20 + k); lu_data = 32'hA00 + k;
            step();
        end
        idle();
        step();
        chk("t5_drain_started", rd_num, 20);
        rst = 1;
        step();
        rst = 0;
        rs_num = 21; rt_num = 22;
        #1;
        chk("t5_rd_we", rd_we, 0);
        chk("t5_lu_ready", lu_ready, 1);
        chk("t5_drained", drained, 1);
        chk("t5_rs_busy", rs_busy, 0);
        chk("t5_rt_busy", rt_busy, 0);
        idle();

        // WAW: pipeline write to a register with a long-latency write outstanding.
        sb_set = 1; sb_num = 5;
        step();
        idle();
        pipe_we = 1; pipe_num = 5; pipe_data = 32'h77;
        step();
        idle();
        step();
        step();
        chk("t6_err_sticky", err, ERR_ON);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("t6_err_cleared", err, 0);

        for (int n = 0; n < 600; n++) begin
            rst = $urandom_range(0, 59) == 0;
            pipe_we = $urandom_range(0, 9) < 3;
            pipe_num = 5'($urandom_range(0, 7));
            pipe_data = $urandom;
            lu_valid = $urandom_range(0, 1) == 1;
            lu_num = 5'($urandom_range(0, 7));
            lu_data = $urandom;
            sb_set = $urandom_range(0, 9) < 4;
            sb_num = 5'($urandom_range(0, 7));
            rs_num = 5'($urandom_range(0, 7));
            rt_num = 5'($urandom_range(0, 31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
